uart_tx_fifo: RTL and testbench

//   Buffered UART transmitter: a byte FIFO behind a valid/ready write port, drained by a

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO behind a valid/ready port, drained by a serialiser.
// Define UART_TX_FIFO_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_fifo #(
  parameter int input_clk_hz    = 12_000_000,
  parameter int baud_rate       = 9600,
  parameter int fifo_depth_log2 = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [fifo_depth_log2:0] o_count
);

  localparam int CLKS_PER_BIT = input_clk_hz / baud_rate;
  localparam int DEPTH        = 1 << fifo_depth_log2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_FIFO_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                     state, state_n;
  logic [CNT_W-1:0]           baud_cnt, baud_n;
  logic [2:0]                 bit_idx, bit_n;
  logic [7:0]                 shift_reg, shift_n;
  logic                       tx_reg, tx_n;
  logic                       bit_done;
  logic                       push, pop, empty;

  logic [7:0]                 mem [DEPTH];
  logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
  logic [fifo_depth_log2:0]   count;

  // Full/empty come from the registered count, so a byte pushed into an empty
  // FIFO is never popped on the same edge.
  assign empty    = (count == '0);
  assign o_ready  = ~count[fifo_depth_log2];
  assign push     = i_valid & o_ready;
  assign o_count  = count;
  assign o_busy   = (state != IDLE) | ~empty;
  assign o_tx     = tx_reg;
  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; pointers and count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      tx_reg    <= tx_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    tx_n    = tx_reg;
    pop     = 1'b0;
    if (state != IDLE) baud_n = bit_done ? '0 : baud_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_n   = '0;
          tx_n    = shift_reg[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
            tx_n    = ^shift_reg;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shift_reg[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_done) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo at CLKS_PER_BIT=10, depth 16; honours UART_TX_FIFO_PARITY_EN.
module tb_uart_tx_fifo;

  localparam int CPB = 10;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam int FRAME_CYC = 11 * CPB;
`else
  localparam int FRAME_CYC = 10 * CPB;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_busy;
  logic [4:0] o_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_bytes [64];
  logic       rdy_hist  [2048];
  logic       busy_hist [2048];
  logic [4:0] cnt_hist  [2048];

  uart_tx_fifo #(
    .input_clk_hz   (1000),
    .baud_rate      (100),
    .fifo_depth_log2(4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // Line level during bit-time k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_FIFO_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge with the DUT idle. Offers tx_bytes[0..n-1] on consecutive
  // ready cycles (garbage with i_valid high while full) and checks o_tx every cycle.
  task automatic stream(input int n, output int accepted);
    int   total;
    logic exp_bit;
    total    = n * FRAME_CYC;
    accepted = 0;
    for (int c = 0; c <= total + 2; c++) begin
      rdy_hist[c]  = o_ready;
      busy_hist[c] = o_busy;
      cnt_hist[c]  = o_count;
      exp_bit = (c >= 2 && c < total + 2) ?
                frame_bit(tx_bytes[(c-2)/FRAME_CYC], ((c-2) % FRAME_CYC) / CPB) : 1'b1;
      checks++;
      if (o_tx !== exp_bit) begin
        errors++;
        $display("FAIL tx_line cycle %0d: got %b expected %b", c, o_tx, exp_bit);
      end
      if (accepted < n && o_ready) begin
        i_valid = 1'b1;
        i_data  = tx_bytes[accepted];
        accepted++;
      end else if (!o_ready) begin
        i_valid = 1'b1;
        i_data  = 8'hEE;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_tx !== 1'b1 || o_count !== 5'd0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b cnt=%0d rdy=%b busy=%b expected 1 0 1 0",
               o_tx, o_count, o_ready, o_busy);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single_frame();
    int acc;
    tx_bytes[0] = 8'hA5;
    stream(1, acc);
    checks++;
    if (busy_hist[FRAME_CYC + 1] !== 1'b1 || busy_hist[FRAME_CYC + 2] !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got %b,%b expected 1,0",
               busy_hist[FRAME_CYC + 1], busy_hist[FRAME_CYC + 2]);
    end
    checks++;
    if (cnt_hist[1] !== 5'd1 || cnt_hist[2] !== 5'd0) begin
      errors++;
      $display("FAIL single_count: got %0d,%0d expected 1,0", cnt_hist[1], cnt_hist[2]);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int peak;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'h55; tx_bytes[3] = 8'h0F;
    stream(4, acc);
    peak = 0;
    for (int c = 0; c < 4 * FRAME_CYC; c++) if (int'(cnt_hist[c]) > peak) peak = int'(cnt_hist[c]);
    checks++;
    if (peak != 3) begin
      errors++;
      $display("FAIL b2b_peak_count: got %0d expected 3", peak);
    end
    checks++;
    if (busy_hist[4 * FRAME_CYC + 2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_end: got %b expected 0", busy_hist[4 * FRAME_CYC + 2]);
    end
  endtask

  task automatic test_full();
    int acc;
    for (int i = 0; i < 17; i++) tx_bytes[i] = 8'h10 + 8'(i);
    stream(17, acc);
    checks++;
    if (acc != 17) begin
      errors++;
      $display("FAIL full_accepted: got %0d expected 17", acc);
    end
    checks++;
    if (cnt_hist[17] !== 5'd16 || rdy_hist[17] !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got cnt=%0d rdy=%b expected 16 0", cnt_hist[17], rdy_hist[17]);
    end
    checks++;
    if (rdy_hist[FRAME_CYC + 1] !== 1'b0 || rdy_hist[FRAME_CYC + 2] !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_return: got %b,%b expected 0,1",
               rdy_hist[FRAME_CYC + 1], rdy_hist[FRAME_CYC + 2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    i_valid = 1'b1; i_data = 8'h3C;
    @(negedge i_clk);
    i_data = 8'hC3;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (45) @(negedge i_clk);
    checks++;
    if (o_tx !== 1'b1 || o_count !== 5'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got tx=%b cnt=%0d busy=%b expected 1 1 1", o_tx, o_count, o_busy);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_tx !== 1'b1 || o_count !== 5'd0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tx=%b cnt=%0d rdy=%b busy=%b expected 1 0 1 0",
               o_tx, o_count, o_ready, o_busy);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    tx_bytes[0] = 8'h81;
    stream(1, acc);
  endtask

  task automatic test_wrap();
    int acc;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) tx_bytes[i] = 8'((b * 10 + i) * 37 + 5);
      stream(10, acc);
      checks++;
      if (acc != 10 || busy_hist[10 * FRAME_CYC + 2] !== 1'b0) begin
        errors++;
        $display("FAIL wrap_burst %0d: got acc=%0d busy=%b expected 10 0",
                 b, acc, busy_hist[10 * FRAME_CYC + 2]);
      end
    end
  endtask

  task automatic test_parity();
    int acc;
    tx_bytes[0] = 8'h07; tx_bytes[1] = 8'h03;
    stream(2, acc);
    checks++;
    if (busy_hist[FRAME_CYC + 2] !== 1'b1 || busy_hist[2 * FRAME_CYC + 2] !== 1'b0) begin
      errors++;
      $display("FAIL parity_frame_len: got %b,%b expected 1,0",
               busy_hist[FRAME_CYC + 2], busy_hist[2 * FRAME_CYC + 2]);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full();
    test_reset_mid_frame();
    test_wrap();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
